keypad_time_loader: RTL and testbench
=====================================

// Module: keypad_time_loader
// PURPOSE
//  Upstream entry stage of the microwave controller: conditions the raw 10-key
//  one-hot keypad, debounces each press, and shift-loads the accepted decimal
//  digits into a 3-digit BCD cook-time register (min : sec_tens sec_ones).
//  The register feeds the countdown/magnetron control stage and the 7-seg
//  decoders. One digit is accepted per physical press.
// PARAMETERS
//  DEBOUNCE_CYCLES  3   consecutive stable samples required to accept a press or release (>=1)
//  KEY_W            10  keypad width; bit k = decimal digit k
// PORTS
//  clock        in   1  system clock (100 Hz); all state on rising edge
//  reset        in   1  asynchronous, active-high; clears all state
//  keys         in   10 raw keypad, bit k high = key k held; asynchronous to clock
//  load_en      in   1  high = digits may be loaded (countdown idle)
//  clear_entry  in   1  synchronous clear of entered time, one-cycle or held
//  sec_ones     out  4  BCD seconds-ones digit
//  sec_tens     out  4  BCD seconds-tens digit
//  min          out  4  BCD minutes digit
//  digit        out  4  BCD value of last accepted key
//  digit_strobe out  1  one-cycle pulse when a digit is shifted in
//  key_error    out  1  high while a multi-hot key pattern is held
//  time_nonzero out  1  registered; high when {min,sec_tens,sec_ones} != 0
// BEHAVIOUR
//  - Reset: all outputs 0, sync flops 0, debounce counter 0, FSM = IDLE.
//  - keys passes a 2-flop synchroniser -> ksync; only ksync used downstream.
//  - FSM states: IDLE, PRESS_DB, WAIT_REL, REL_DB.
//    IDLE: ksync one-hot -> latch candidate, cnt=1, PRESS_DB; multi-hot -> WAIT_REL, key_error=1.
//    PRESS_DB: ksync==candidate -> cnt++; ksync changes (other one-hot) -> new candidate, cnt=1;
//      ksync==0 -> IDLE (glitch, nothing accepted); multi-hot -> WAIT_REL, key_error=1.
//      When cnt reaches DEBOUNCE_CYCLES: accept, go WAIT_REL.
//    WAIT_REL: ksync==0 -> REL_DB, cnt=1; key_error tracks multi-hot ksync.
//    REL_DB: ksync==0 for DEBOUNCE_CYCLES samples -> IDLE; any nonzero -> WAIT_REL.
//  - Accept: on the accepting edge, if load_en=1: min<=sec_tens, sec_tens<=sec_ones,
//    sec_ones<=candidate index, digit<=index, digit_strobe=1 for exactly that cycle.
//    If load_en=0 the press is consumed (FSM still advances) with no shift and no strobe.
//  - Latency: key held from edge n -> strobe high after edge n+1+DEBOUNCE_CYCLES.
//  - A key held indefinitely yields one digit only; next digit needs a debounced release.
//  - clear_entry=1: min/sec_tens/sec_ones/digit <= 0 on next edge; wins over a
//    simultaneous accept (strobe still pulses, digits read 0). FSM unaffected.
//  - Digits stored as entered; no range check on sec_tens (>5 legal here,
//    normalised by countdown stage). Oldest digit (min) discarded on shift.
//  - time_nonzero updates one cycle after digit register.
//  - Reset mid-debounce: immediate return to reset state; press in progress is
//    not accepted unless re-debounced after reset release.
// CONFIGURATION
//  KEYPAD_ENTRY_LIMIT_EN defined: 2-bit entry count; after 3 accepted digits,
//    further presses are consumed without shift/strobe until clear_entry or reset
//    zeroes the count.
//  Undefined: unlimited entry; each accepted digit shifts, oldest digit lost.
// TESTING
//  1. keys=1,2,8 each held 5 cycles, 15-cycle gaps, load_en=1 -> 3 strobes; min=1 sec_tens=2 sec_ones=8, time_nonzero=1.
//  2. keys=0000000100 for 1 cycle only -> no strobe, digits unchanged, FSM back to IDLE.
//  3. keys=0000100010 held 6 cycles -> key_error=1 while held, no strobe, digits unchanged.
//  4. After 1:28, clear_entry pulse coincident with accept of key 5 -> strobe=1, all digits 0, time_nonzero=0 next cycle.
//  5. Enter 1,2,8,4: macro undefined -> 2:84; KEYPAD_ENTRY_LIMIT_EN -> 1:28, 3 strobes only.
//  6. reset asserted during PRESS_DB of key 7, released, key still held -> accepted DEBOUNCE_CYCLES+2 edges after release, sec_ones=7.

Source files
------------

// File: rtl/keypad_time_loader.sv
`timescale 1ns/1ps
// keypad_time_loader
// Keypad entry stage of the microwave controller. Synchronises the raw
// one-hot keypad, debounces press and release, and shift-loads accepted
// decimal digits into a 3-digit BCD cook-time register (min : tens ones).
// Optional feature macro: KEYPAD_ENTRY_LIMIT_EN. When it is defined, at most
// three digits are accepted until clear_entry or reset.
module keypad_time_loader #(
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int KEY_W           = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [KEY_W-1:0] keys,
   input  logic             load_en,
   input  logic             clear_entry,
   output logic [3:0]       sec_ones,
   output logic [3:0]       sec_tens,
   output logic [3:0]       min,
   output logic [3:0]       digit,
   output logic             digit_strobe,
   output logic             key_error,
   output logic             time_nonzero
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   // Count value meaning "this sample is the last one needed".
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      WAIT_REL = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   // Exactly one key held.
   function automatic logic is_onehot(input logic [KEY_W-1:0] k);
      return (k != '0) && ((k & (k - KEY_W'(1))) == '0);
   endfunction

   // Two or more keys held at once.
   function automatic logic is_multi(input logic [KEY_W-1:0] k);
      return (k != '0) && !is_onehot(k);
   endfunction

   // Decimal index of a one-hot key vector.
   function automatic logic [3:0] key_index(input logic [KEY_W-1:0] k);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < KEY_W; i++) begin
         if (k[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   logic [KEY_W-1:0] ksync_p0;
   logic [KEY_W-1:0] ksync_p1;
   logic [KEY_W-1:0] ksync;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [KEY_W-1:0] cand_q, cand_d;
   logic             accept;
   logic [3:0]       accept_idx;
   logic             shift_en;

`ifdef KEYPAD_ENTRY_LIMIT_EN
   logic [1:0]       entry_cnt;
`endif

   // Two-flop synchroniser for the asynchronous keypad lines.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ksync_p0 <= '0;
         ksync_p1 <= '0;
      end else begin
         ksync_p0 <= keys;
         ksync_p1 <= ksync_p0;
      end
   end

   assign ksync = ksync_p1;

   // Debounce FSM state, sample counter and candidate key register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cand_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
      end
   end

   // Next-state logic: press debounce, acceptance, then release debounce.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_onehot(ksync)) begin
               cand_d = ksync;
               if (DEBOUNCE_CYCLES <= 1) begin
                  accept  = 1'b1;
                  state_d = WAIT_REL;
               end else begin
                  cnt_d   = CNT_ONE;
                  state_d = PRESS_DB;
               end
            end else if (is_multi(ksync)) begin
               state_d = WAIT_REL;
            end
         end
         PRESS_DB: begin
            if (ksync == '0) begin
               // Glitch shorter than the debounce window: drop it.
               cnt_d   = '0;
               state_d = IDLE;
            end else if (is_multi(ksync)) begin
               state_d = WAIT_REL;
            end else if (ksync != cand_q) begin
               // Finger slid to another key: restart on the new one.
               cand_d = ksync;
               cnt_d  = CNT_ONE;
            end else if (cnt_q == CNT_LAST) begin
               accept  = 1'b1;
               state_d = WAIT_REL;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         WAIT_REL: begin
            if (ksync == '0) begin
               if (DEBOUNCE_CYCLES <= 1) begin
                  state_d = IDLE;
               end else begin
                  cnt_d   = CNT_ONE;
                  state_d = REL_DB;
               end
            end
         end
         REL_DB: begin
            if (ksync != '0) begin
               // Release bounced: keep waiting for a clean release.
               state_d = WAIT_REL;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign accept_idx = key_index(cand_d);

`ifdef KEYPAD_ENTRY_LIMIT_EN
   assign shift_en = accept && load_en && (entry_cnt != 2'd3);

   // Entry counter: blocks further digits once three have been taken.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         entry_cnt <= '0;
      end else if (clear_entry) begin
         entry_cnt <= '0;
      end else if (shift_en) begin
         entry_cnt <= entry_cnt + 2'd1;
      end
   end
`else
   assign shift_en = accept && load_en;
`endif

   // Digit shift register, strobe, error flag and nonzero flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sec_ones     <= '0;
         sec_tens     <= '0;
         min          <= '0;
         digit        <= '0;
         digit_strobe <= 1'b0;
         key_error    <= 1'b0;
         time_nonzero <= 1'b0;
      end else begin
         digit_strobe <= shift_en;
         key_error    <= is_multi(ksync);
         // Reflects the digit register as it stood before this edge.
         time_nonzero <= ({min, sec_tens, sec_ones} != 12'd0);
         if (clear_entry) begin
            // Clear wins over a coincident accept; strobe still pulses.
            sec_ones <= '0;
            sec_tens <= '0;
            min      <= '0;
            digit    <= '0;
         end else if (shift_en) begin
            min      <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= accept_idx;
            digit    <= accept_idx;
         end
      end
   end

endmodule

// File: tb/tb_keypad_time_loader.sv
`timescale 1ns/1ps
// Bench for keypad_time_loader: table of press scenarios, hand-written
// reset-during-debounce sequence, then randomized presses checked each cycle
// against a press-level reference model.
module tb_keypad_time_loader;

   localparam int D = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] keys = '0;
   logic       load_en = 1'b0;
   logic       clear_entry = 1'b0;
   logic [3:0] sec_ones, sec_tens, min, digit;
   logic       digit_strobe, key_error, time_nonzero;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   keypad_time_loader #(.DEBOUNCE_CYCLES(D), .KEY_W(10)) dut (
      .clock        (clock),
      .reset        (reset),
      .keys         (keys),
      .load_en      (load_en),
      .clear_entry  (clear_entry),
      .sec_ones     (sec_ones),
      .sec_tens     (sec_tens),
      .min          (min),
      .digit        (digit),
      .digit_strobe (digit_strobe),
      .key_error    (key_error),
      .time_nonzero (time_nonzero)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Apply inputs at a falling edge, let one rising edge pass, return at the next falling edge.
   task automatic step(input logic [9:0] k, input logic ld, input logic clr);
      keys        = k;
      load_en     = ld;
      clear_entry = clr;
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({min, sec_tens, sec_ones, digit, digit_strobe, key_error, time_nonzero});
   endfunction

   typedef struct {
      logic [9:0]  k;
      int          hold;
      int          gap;
      logic        ld;
      int          clr_off;
      int          exp_strobes;
      logic [11:0] exp_time;
      logic [3:0]  exp_digit;
      logic        exp_err;
   } vec_t;

   vec_t tbl[11];

   localparam logic [9:0] K1 = 10'b0000000010;
   localparam logic [9:0] K2 = 10'b0000000100;
   localparam logic [9:0] K4 = 10'b0000010000;
   localparam logic [9:0] K5 = 10'b0000100000;
   localparam logic [9:0] K7 = 10'b0010000000;
   localparam logic [9:0] K8 = 10'b0100000000;

   int          ns, cnt_early;
   logic        es;
   logic [9:0]  pk, k, h0, h1;
   int          hold, gap, m_cnt, idx;
   logic        ld, clr, acc, sh, nz_new, err_new;
   logic [3:0]  m_min, m_tens, m_ones, m_digit;
   logic        m_strobe, m_err, m_nz;
   logic [31:0] exp_v;

   initial begin
      tbl[0]  = '{K1, 5, 15, 1'b1, -1, 1, 12'h001, 4'd1, 1'b0};
      tbl[1]  = '{K2, 5, 15, 1'b1, -1, 1, 12'h012, 4'd2, 1'b0};
      tbl[2]  = '{K8, 5, 15, 1'b1, -1, 1, 12'h128, 4'd8, 1'b0};
      tbl[3]  = '{K2, 1, 15, 1'b1, -1, 0, 12'h128, 4'd8, 1'b0};
      tbl[4]  = '{10'b0000100010, 6, 15, 1'b1, -1, 0, 12'h128, 4'd8, 1'b1};
      tbl[5]  = '{K5, 5, 15, 1'b1, 1 + D, 1, 12'h000, 4'd0, 1'b0};
      tbl[6]  = '{K4, 5, 15, 1'b0, -1, 0, 12'h000, 4'd0, 1'b0};
      tbl[7]  = '{K1, 5, 15, 1'b1, -1, 1, 12'h001, 4'd1, 1'b0};
      tbl[8]  = '{K2, 5, 15, 1'b1, -1, 1, 12'h012, 4'd2, 1'b0};
      tbl[9]  = '{K8, 5, 15, 1'b1, -1, 1, 12'h128, 4'd8, 1'b0};
`ifdef KEYPAD_ENTRY_LIMIT_EN
      tbl[10] = '{K4, 5, 15, 1'b1, -1, 0, 12'h128, 4'd8, 1'b0};
`else
      tbl[10] = '{K4, 5, 15, 1'b1, -1, 1, 12'h284, 4'd4, 1'b0};
`endif

      // Reset state
      repeat (3) @(negedge clock);
      check("reset_state", all_outs(), 32'd0);
      reset = 1'b0;
      repeat (3) step('0, 1'b1, 1'b0);

      // Table-driven press scenarios
      for (int r = 0; r < 11; r++) begin
         ns = 0;
         es = 1'b0;
         for (int j = 0; j < tbl[r].hold + tbl[r].gap; j++) begin
            step((j < tbl[r].hold) ? tbl[r].k : 10'd0, tbl[r].ld, (j == tbl[r].clr_off));
            if (digit_strobe) ns++;
            if (key_error) es = 1'b1;
         end
         check($sformatf("row%0d_strobes", r), 32'(ns), 32'(tbl[r].exp_strobes));
         check($sformatf("row%0d_time", r), 32'({min, sec_tens, sec_ones}), 32'(tbl[r].exp_time));
         check($sformatf("row%0d_digit", r), 32'(digit), 32'(tbl[r].exp_digit));
         check($sformatf("row%0d_key_error", r), 32'(es), 32'(tbl[r].exp_err));
         check($sformatf("row%0d_nonzero", r), 32'(time_nonzero), 32'(tbl[r].exp_time != 12'h000));
      end

      // Reset asserted while key 7 is in press debounce
      step(K7, 1'b1, 1'b0);
      step(K7, 1'b1, 1'b0);
      step(K7, 1'b1, 1'b0);
      reset = 1'b1;
      #1;
      check("async_reset_clears", all_outs(), 32'd0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      cnt_early = 0;
      for (int i = 0; i < D + 1; i++) begin
         step(K7, 1'b1, 1'b0);
         if (digit_strobe) cnt_early++;
      end
      check("post_reset_no_early_strobe", 32'(cnt_early), 32'd0);
      step(K7, 1'b1, 1'b0);
      check("post_reset_strobe", 32'(digit_strobe), 32'd1);
      check("post_reset_time", 32'({min, sec_tens, sec_ones}), 32'h007);
      // Key kept held: no second digit
      cnt_early = 0;
      for (int i = 0; i < 10; i++) begin
         step(K7, 1'b1, 1'b0);
         if (digit_strobe) cnt_early++;
      end
      check("held_key_single_digit", 32'(cnt_early), 32'd0);
      repeat (10) step('0, 1'b1, 1'b0);

      // Randomized presses against the reference model
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      m_min = '0; m_tens = '0; m_ones = '0; m_digit = '0;
      m_strobe = 1'b0; m_err = 1'b0; m_nz = 1'b0; m_cnt = 0;
      h0 = '0; h1 = '0;
      for (int p = 0; p < 80; p++) begin
         case ($urandom_range(0, 9))
            0, 1: begin
               idx = $urandom_range(0, 9);
               pk  = 10'(1) << idx;
               pk  = pk | (10'(1) << ((idx + 1 + $urandom_range(0, 8)) % 10));
            end
            default: pk = 10'(1) << $urandom_range(0, 9);
         endcase
         hold = $urandom_range(1, 7);
         gap  = $urandom_range(D + 2, D + 8);
         ld   = ($urandom_range(0, 4) != 0);
         for (int j = 0; j < hold + gap; j++) begin
            k   = (j < hold) ? pk : 10'd0;
            clr = ($urandom_range(0, 11) == 0);
            // A single-key press held for D samples is taken D+1 edges after it starts.
            acc = ($countones(pk) == 1) && (hold >= D) && (j == 1 + D);
            step(k, ld, clr);
            nz_new  = ({m_min, m_tens, m_ones} != 12'h000);
            err_new = ($countones(h1) > 1);
            sh = acc && ld;
`ifdef KEYPAD_ENTRY_LIMIT_EN
            sh = sh && (m_cnt < 3);
`endif
            m_strobe = sh;
            if (sh) begin
               m_min   = m_tens;
               m_tens  = m_ones;
               m_ones  = 4'($clog2(pk));
               m_digit = 4'($clog2(pk));
               m_cnt++;
            end
            if (clr) begin
               m_min = '0; m_tens = '0; m_ones = '0; m_digit = '0;
               m_cnt = 0;
            end
            m_err = err_new;
            m_nz  = nz_new;
            h1 = h0;
            h0 = k;
            exp_v = 32'({m_min, m_tens, m_ones, m_digit, m_strobe, m_err, m_nz});
            check($sformatf("rand_p%0d_c%0d", p, j), all_outs(), exp_v);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
